// File: rtl/uart_pkg.sv
// uart_pkg
//   Shared definitions for the UART transmit queue slice.
//   UART_BYTE_W : width of one UART character.
//   tx_state_e  : states of the launch sequencer in uart_tx_queue.
package uart_pkg;

   localparam int UART_BYTE_W = 8;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_BUSY = 2'd1,
      WAIT_DONE = 2'd2
   } tx_state_e;

endpackage

// File: rtl/uart_tx_queue_if.sv
// uart_tx_queue_if
//   Bundles the producer write port and the transmitter start/busy port of
//   uart_tx_queue.
//   Producer side : wr_en, wr_data -> queue ; full, empty, count, overflow <- queue
//   Transmitter   : tx_start, tx_data <- queue ; tx_busy -> queue
//   Handshake: a byte is taken on a rising edge where wr_en=1 and full=0;
//   wr_en=1 with full=1 drops the byte and pulses overflow for one cycle.
//   tx_start is a one-cycle pulse, only raised after tx_busy was sampled low;
//   tx_data stays stable from that pulse until the next one.
//   master : environment side (producer plus transmitter)
//   slave  : the queue itself
interface uart_tx_queue_if
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) ();

   localparam int CW = $clog2(DEPTH) + 1;

   logic                   wr_en;
   logic [UART_BYTE_W-1:0] wr_data;
   logic                   full;
   logic                   empty;
   logic [CW-1:0]          count;
   logic                   overflow;
   logic                   tx_start;
   logic [UART_BYTE_W-1:0] tx_data;
   logic                   tx_busy;

   modport master (
      output wr_en, wr_data, tx_busy,
      input  full, empty, count, overflow, tx_start, tx_data
   );

   modport slave (
      input  wr_en, wr_data, tx_busy,
      output full, empty, count, overflow, tx_start, tx_data
   );

endinterface

// File: rtl/uart_tx_queue_byte_fifo.sv
// byte_fifo
//   DEPTH x UART_BYTE_W circular buffer with a separate occupancy counter.
//   clk, rst_n   : clock, synchronous active-low reset
//   push_i       : write request; accepted only when full_o=0
//   push_data_i  : byte to store
//   pop_i        : read request; ignored when empty_o=1
//   rd_data_o    : byte at the head of the queue
//   full_o       : count_o == DEPTH
//   empty_o      : count_o == 0
//   count_o      : bytes currently stored
//   overflow_o   : one-cycle pulse after a push was dropped because full
module byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push_i,
   input  logic [UART_BYTE_W-1:0]       push_data_i,
   input  logic                         pop_i,
   output logic [UART_BYTE_W-1:0]       rd_data_o,
   output logic                         full_o,
   output logic                         empty_o,
   output logic [$clog2(DEPTH):0]       count_o,
   output logic                         overflow_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [UART_BYTE_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]          count_q, count_d;
   logic                   overflow_q, overflow_d;
   logic                   push_ok, pop_ok;

   // Full/empty come from the registered count only, so a pop on the same
   // edge never makes room for a push and a push is never popped at once.
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

   assign push_ok = push_i & ~full_o;
   assign pop_ok  = pop_i & ~empty_o;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      overflow_d = push_i & full_o;
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage needs no reset: resetting the pointers and count discards it.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign rd_data_o  = mem_q[rd_ptr_q];
   assign count_o    = count_q;
   assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_tx_queue.sv
// uart_tx_queue
//   Byte queue plus launch sequencer in front of a UART transmitter.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : uart_tx_queue_if.slave (producer write port and
//                transmitter start/busy port)
//   state_o    : current launch sequencer state, for observation
module uart_tx_queue
   import uart_pkg::*;
#(
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_tx_queue_if.slave   bus,
   output tx_state_e        state_o
);

   logic [UART_BYTE_W-1:0] fifo_rd_data;
   logic                   fifo_empty;
   logic                   pop;

   tx_state_e              state_q, state_d;
   logic                   tx_start_q, tx_start_d;
   logic [UART_BYTE_W-1:0] tx_data_q, tx_data_d;

   byte_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (bus.wr_en),
      .push_data_i (bus.wr_data),
      .pop_i       (pop),
      .rd_data_o   (fifo_rd_data),
      .full_o      (bus.full),
      .empty_o     (fifo_empty),
      .count_o     (bus.count),
      .overflow_o  (bus.overflow)
   );

   // IDLE launches only when the transmitter reports idle, so after a reset
   // in mid-byte the sequencer naturally waits for the old byte to finish.
   // WAIT_BUSY has no timeout: the transmitter always raises busy after it
   // samples start.
   always_comb begin
      state_d    = state_q;
      tx_start_d = 1'b0;
      tx_data_d  = tx_data_q;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty && !bus.tx_busy) begin
               pop        = 1'b1;
               tx_start_d = 1'b1;
               tx_data_d  = fifo_rd_data;
               state_d    = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            if (bus.tx_busy) state_d = WAIT_DONE;
         end
         WAIT_DONE: begin
            if (!bus.tx_busy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         tx_start_q <= 1'b0;
         tx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         tx_start_q <= tx_start_d;
         tx_data_q  <= tx_data_d;
      end
   end

   assign bus.empty    = fifo_empty;
   assign bus.tx_start = tx_start_q;
   assign bus.tx_data  = tx_data_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// tb_uart_tx_queue
//   Directed bench for uart_tx_queue: one DEPTH=16 instance and one DEPTH=4
//   instance, each driven by a model transmitter that latches tx_data on
//   start and stays busy for a fixed number of cycles afterwards.
module tb_uart_tx_queue;
   import uart_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   uart_tx_queue_if #(.DEPTH(16)) bus16 ();
   uart_tx_queue_if #(.DEPTH(4))  bus4 ();
   tx_state_e state16, state4;

   uart_tx_queue #(.DEPTH(16)) u_dut16 (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus16.slave),
      .state_o (state16)
   );

   uart_tx_queue #(.DEPTH(4)) u_dut4 (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus4.slave),
      .state_o (state4)
   );

   // ---------------- scoreboard state ----------------
   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] exp_q16[$];
   logic [7:0] exp_q4[$];
   int n_tx16 = 0, n_tx4 = 0;
   int ovf16 = 0, ovf4 = 0;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // ---------------- model transmitters ----------------
   logic busy16 = 1'b0, force_busy16 = 1'b0;
   int   cnt16 = 0;
   assign bus16.tx_busy = busy16 | force_busy16;

   always @(posedge clk) begin
      if (bus16.tx_start) begin
         check_eq("start_while_busy16", {31'b0, bus16.tx_busy}, 32'd0);
         check_eq("sb_nonempty16", {31'b0, exp_q16.size() != 0}, 32'd1);
         if (exp_q16.size() != 0) check_eq("tx_data16", {24'b0, bus16.tx_data}, {24'b0, exp_q16.pop_front()});
         busy16 <= 1'b1;
         cnt16  <= 10;
         n_tx16++;
      end else if (busy16) begin
         cnt16 <= cnt16 - 1;
         if (cnt16 == 1) busy16 <= 1'b0;
      end
   end

   logic busy4 = 1'b0;
   int   cnt4 = 0;
   assign bus4.tx_busy = busy4;

   always @(posedge clk) begin
      if (bus4.tx_start) begin
         check_eq("start_while_busy4", {31'b0, bus4.tx_busy}, 32'd0);
         check_eq("sb_nonempty4", {31'b0, exp_q4.size() != 0}, 32'd1);
         if (exp_q4.size() != 0) check_eq("tx_data4", {24'b0, bus4.tx_data}, {24'b0, exp_q4.pop_front()});
         busy4 <= 1'b1;
         cnt4  <= 3;
         n_tx4++;
      end else if (busy4) begin
         cnt4 <= cnt4 - 1;
         if (cnt4 == 1) busy4 <= 1'b0;
      end
   end

   always @(posedge clk) begin
      if (bus16.overflow) ovf16++;
      if (bus4.overflow)  ovf4++;
   end

   // ---------------- driver tasks ----------------
   task automatic write16(input logic [7:0] d);
      @(negedge clk);
      bus16.wr_en   = 1'b1;
      bus16.wr_data = d;
      if (!bus16.full) exp_q16.push_back(d);
   endtask

   task automatic idle16();
      @(negedge clk);
      bus16.wr_en = 1'b0;
   endtask

   task automatic wait_drain16(input string tag);
      int t = 0;
      while (!(bus16.empty && state16 == IDLE && !bus16.tx_busy) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check_eq(tag, {31'b0, t < 2000}, 32'd1);
   endtask

   task automatic check_reset16(input string tag);
      check_eq({tag, "_full"},     {31'b0, bus16.full},     32'd0);
      check_eq({tag, "_empty"},    {31'b0, bus16.empty},    32'd1);
      check_eq({tag, "_count"},    {27'b0, bus16.count},    32'd0);
      check_eq({tag, "_overflow"}, {31'b0, bus16.overflow}, 32'd0);
      check_eq({tag, "_tx_start"}, {31'b0, bus16.tx_start}, 32'd0);
      check_eq({tag, "_tx_data"},  {24'b0, bus16.tx_data},  32'd0);
      check_eq({tag, "_state"},    {30'b0, state16},        32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int n0, o0, t, sent;
      logic saw_full;

      rst_n = 1'b0;
      bus16.wr_en = 1'b0; bus16.wr_data = '0;
      bus4.wr_en  = 1'b0; bus4.wr_data  = '0;
      repeat (3) @(negedge clk);
      check_reset16("rst");
      check_eq("rst4_empty", {31'b0, bus4.empty}, 32'd1);
      check_eq("rst4_count", {28'b0, bus4.count}, 32'd0);
      rst_n = 1'b1;

      // single byte: launch pulse appears in the cycle after edge N+1
      write16(8'hA5);
      idle16();
      check_eq("t1_start_n",   {31'b0, bus16.tx_start}, 32'd0);
      check_eq("t1_count_n",   {27'b0, bus16.count},    32'd1);
      @(negedge clk);
      check_eq("t1_start_n1",  {31'b0, bus16.tx_start}, 32'd1);
      check_eq("t1_data_n1",   {24'b0, bus16.tx_data},  32'h0000_00A5);
      check_eq("t1_count_n1",  {27'b0, bus16.count},    32'd0);
      @(negedge clk);
      check_eq("t1_start_low", {31'b0, bus16.tx_start}, 32'd0);
      wait_drain16("t1_drain");
      check_eq("t1_ntx", n_tx16, 32'd1);

      // burst 01..10 on consecutive cycles
      n0 = n_tx16; o0 = ovf16;
      for (int i = 1; i <= 16; i++) write16(8'(i));
      idle16();
      wait_drain16("t2_drain");
      check_eq("t2_ntx",     n_tx16 - n0,     32'd16);
      check_eq("t2_ovf",     ovf16 - o0,      32'd0);
      check_eq("t2_sb_left", exp_q16.size(),  32'd0);

      // fill while transmitter is busy, then overflow with EE
      n0 = n_tx16; o0 = ovf16;
      force_busy16 = 1'b1;
      for (int i = 0; i < 16; i++) write16(8'h40 + 8'(i));
      idle16();
      check_eq("t3_full",  {31'b0, bus16.full},  32'd1);
      check_eq("t3_count", {27'b0, bus16.count}, 32'd16);
      write16(8'hEE);
      idle16();
      check_eq("t3_ovf",       {31'b0, bus16.overflow}, 32'd1);
      check_eq("t3_count_ovf", {27'b0, bus16.count},    32'd16);
      @(negedge clk);
      check_eq("t3_ovf_pulse", {31'b0, bus16.overflow}, 32'd0);

      // write while full on the same edge as a launch: still dropped
      write16(8'hDD);
      force_busy16 = 1'b0;
      idle16();
      check_eq("t4_ovf",   {31'b0, bus16.overflow}, 32'd1);
      check_eq("t4_count", {27'b0, bus16.count},    32'd15);
      check_eq("t4_start", {31'b0, bus16.tx_start}, 32'd1);
      check_eq("t4_data",  {24'b0, bus16.tx_data},  32'h0000_0040);
      wait_drain16("t4_drain");
      check_eq("t4_ntx",     n_tx16 - n0,    32'd16);
      check_eq("t4_ovf_tot", ovf16 - o0,     32'd2);
      check_eq("t4_sb_left", exp_q16.size(), 32'd0);

      // reset during WAIT_DONE with three bytes queued
      for (int i = 0; i < 4; i++) write16(8'h60 + 8'(i));
      idle16();
      t = 0;
      while (state16 != WAIT_DONE && t < 200) begin
         @(negedge clk);
         t++;
      end
      check_eq("t5_reach_wait_done", {31'b0, t < 200}, 32'd1);
      check_eq("t5_count_before",    {27'b0, bus16.count}, 32'd3);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check_reset16("t5_rst");
      exp_q16.delete();
      check_eq("t5_tx_still_busy", {31'b0, bus16.tx_busy}, 32'd1);
      n0 = n_tx16;
      write16(8'h77);
      idle16();
      t = 0;
      while (n_tx16 == n0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      check_eq("t5_relaunch_seen", {31'b0, t < 200}, 32'd1);
      wait_drain16("t5_drain");
      check_eq("t5_ntx", n_tx16 - n0, 32'd1);

      // DEPTH=4: 40 bytes through a small ring, writes throttled on full
      sent = 0; t = 0; saw_full = 1'b0;
      while (sent < 40 && t < 5000) begin
         @(negedge clk);
         t++;
         if (bus4.full) saw_full = 1'b1;
         if (!bus4.full) begin
            bus4.wr_en   = 1'b1;
            bus4.wr_data = 8'(sent * 7 + 3);
            exp_q4.push_back(8'(sent * 7 + 3));
            sent++;
         end else begin
            bus4.wr_en = 1'b0;
         end
      end
      @(negedge clk);
      bus4.wr_en = 1'b0;
      t = 0;
      while (!(bus4.empty && state4 == IDLE && !bus4.tx_busy) && t < 2000) begin
         @(negedge clk);
         t++;
      end
      check_eq("t6_drain",     {31'b0, t < 2000}, 32'd1);
      check_eq("t6_ntx",       n_tx4,             32'd40);
      check_eq("t6_ovf",       ovf4,              32'd0);
      check_eq("t6_sb_left",   exp_q4.size(),     32'd0);
      check_eq("t6_full_seen", {31'b0, saw_full}, 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
